// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns IP and IR, fetches over a
// req/ack ROM handshake, strobes execute, counts retirements, halts/faults.
module cpu_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int INSTR_W   = 32,
    parameter int ROM_DEPTH = 256,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               rom_req,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic               rom_ack,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic               exec_en,
    input  logic               ip_incr,
    input  logic               jmp,
    input  logic [ADDR_W-1:0]  jaddr,
    output logic [ADDR_W-1:0]  ip,
    input  logic [CNT_W-1:0]   retire_limit,
    output logic [CNT_W-1:0]   retired,
    output logic               halted,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_ip
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    // One extra bit so ROM_DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(ROM_DEPTH);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  ip_nxt;
    logic [ADDR_W-1:0]  target;
    logic [INSTR_W-1:0] instr_nxt;
    logic [CNT_W-1:0]   retired_nxt;
    logic [CNT_W-1:0]   ret_inc;
    logic               fault_nxt;
    logic [ADDR_W-1:0]  fault_ip_nxt;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= DEPTH;
    endfunction

    assign rom_req  = (state == FETCH);
    assign exec_en  = (state == EXEC);
    assign halted   = (state == HALT);
    assign rom_addr = ip;

    assign ret_inc = retired + CNT_W'(1);

    always_comb begin
        target = ip;
        if (jmp)
            target = jaddr;
        else if (ip_incr)
            target = ip + ADDR_W'(1);
    end

    always_comb begin
        state_nxt    = state;
        ip_nxt       = ip;
        instr_nxt    = instr;
        retired_nxt  = retired;
        fault_nxt    = fault;
        fault_ip_nxt = fault_ip;
        unique case (state)
            IDLE: begin
                if (run) begin
                    if (out_of_range(ip)) begin
                        state_nxt    = HALT;
                        fault_nxt    = 1'b1;
                        fault_ip_nxt = ip;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                if (rom_ack) begin
                    instr_nxt = rom_data;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                ip_nxt      = target;
                retired_nxt = (&retired) ? retired : ret_inc;
                if (retire_limit != '0 && ret_inc == retire_limit) begin
                    state_nxt = HALT;
                end else if (out_of_range(target)) begin
                    state_nxt    = HALT;
                    fault_nxt    = 1'b1;
                    fault_ip_nxt = target;
                end else if (run) begin
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ip       <= '0;
            instr    <= '0;
            retired  <= '0;
            fault    <= 1'b0;
            fault_ip <= '0;
        end else begin
            state    <= state_nxt;
            ip       <= ip_nxt;
            instr    <= instr_nxt;
            retired  <= retired_nxt;
            fault    <= fault_nxt;
            fault_ip <= fault_ip_nxt;
        end
    end

endmodule
